prog_loader: RTL and testbench

//  Upstream neighbour of the instruction RAM in the two-counter machine. Receives a framed

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/loader_timeout.sv | 27 ++
 rtl/prog_loader.sv | 119 +++++++++++
 tb/tb_prog_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the default frame marker.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      SYNC  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      CSUM  = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // States in which the loader consumes stream bytes.
   function automatic logic takes_bytes(input state_t s);
      return (s == SYNC) || (s == LEN) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts while enabled, clears on request, flags the cycle whose edge reaches the limit.
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIM = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear || !en)
         cnt <= '0;
      else if (cnt != LIM)
         cnt <= cnt + CW'(1);
   end

   // Asserted when this edge would be the TIMEOUT_CYCLES-th idle one.
   assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == LIM);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: SYNC, LEN, data, CSUM -> iram writes; holds the core until verified.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int          ADDR_W         = 8,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              restart,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error
);

   localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

   state_t     state, state_d;
   logic [8:0] len, cnt, len_byte;
   logic [7:0] sum;
   logic       acc, expired, tmo_en, tmo_clear;
   logic       in_ready_d, wr_en_d, cpu_hold_d, load_done_d, load_error_d;

   // restart takes priority: a byte offered alongside it is not consumed.
   assign acc       = in_valid && in_ready && !restart;
   assign len_byte  = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
   assign tmo_en    = (state == LEN) || (state == DATA) || (state == CSUM);
   assign tmo_clear = (in_valid && in_ready) || restart;

   loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (CLK),
      .reset  (reset),
      .clear  (tmo_clear),
      .en     (tmo_en),
      .expired(expired)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= SYNC;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         state      <= state_d;
         in_ready   <= in_ready_d;
         wr_en      <= wr_en_d;
         cpu_hold   <= cpu_hold_d;
         load_done  <= load_done_d;
         load_error <= load_error_d;
      end
   end

   always_comb begin
      state_d = state;
      if (restart) begin
         state_d = SYNC;
      end else begin
         unique case (state)
            SYNC:  if (acc && in_data == SYNC_BYTE) state_d = LEN;
            LEN:   if (acc) state_d = (len_byte > DEPTH) ? ERROR : DATA;
                   else if (expired) state_d = ERROR;
            DATA:  if (acc) begin
                      if (cnt == len - 9'd1) state_d = CSUM;
                   end else if (expired) state_d = ERROR;
            CSUM:  if (acc) state_d = (in_data == sum) ? DONE : ERROR;
                   else if (expired) state_d = ERROR;
            default: state_d = state;
         endcase
      end
   end

   always_comb begin
      in_ready_d   = takes_bytes(state_d);
      wr_en_d      = acc && (state == DATA);
      cpu_hold_d   = (state_d != DONE);
      load_done_d  = (state_d == DONE);
      load_error_d = (state_d == ERROR);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         wr_addr <= '0;
         wr_data <= '0;
         len     <= '0;
         cnt     <= '0;
         sum     <= '0;
      end else if (restart) begin
         len <= '0;
         cnt <= '0;
         sum <= '0;
      end else if (acc) begin
         case (state)
            LEN: begin
               len <= len_byte;
               cnt <= '0;
               sum <= '0;
            end
            DATA: begin
               wr_addr <= cnt[ADDR_W-1:0];
               wr_data <= in_data;
               sum     <= sum + in_data;
               cnt     <= cnt + 9'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: write scoreboard plus flag/timing checks on two parameterisations.
module tb_prog_loader;
   import prog_loader_pkg::*;

   logic       CLK = 1'b0, reset = 1'b1, restart = 1'b0;
   logic       in_valid = 1'b0, in_valid4 = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       in_ready, wr_en, cpu_hold, load_done, load_error;
   logic [7:0] wr_addr, wr_data;
   logic       in_ready4, wr_en4, cpu_hold4, load_done4, load_error4;
   logic [3:0] wr_addr4;
   logic [7:0] wr_data4;

   int checks = 0, failures = 0, writes = 0, writes4 = 0, pushes = 0;
   logic [15:0] exp_q[$];

   prog_loader #(.ADDR_W(8), .SYNC_BYTE(SYNC_BYTE_DEF), .TIMEOUT_CYCLES(10)) u_dut (
      .CLK(CLK), .reset(reset), .restart(restart), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error));

   prog_loader #(.ADDR_W(4), .SYNC_BYTE(SYNC_BYTE_DEF), .TIMEOUT_CYCLES(0)) u_dut4 (
      .CLK(CLK), .reset(reset), .restart(restart), .in_valid(in_valid4), .in_data(in_data),
      .in_ready(in_ready4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
      .cpu_hold(cpu_hold4), .load_done(load_done4), .load_error(load_error4));

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int a, input logic [7:0] d);
      exp_q.push_back({8'(a), d});
      pushes++;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
   task automatic send(input logic [7:0] b, input bit four = 1'b0);
      int n = 0;
      in_data = b;
      if (four) in_valid4 = 1'b1; else in_valid = 1'b1;
      @(negedge CLK);
      while (!(four ? in_ready4 : in_ready) && n < 100) begin
         n++;
         @(negedge CLK);
      end
      chk("send_wait_expired", 32'(n >= 100), 0);
      @(posedge CLK); #1;
      in_valid  = 1'b0;
      in_valid4 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(posedge CLK); #1;
      restart = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_cpu_hold"}, cpu_hold, 1);
      chk({tag, "_load_done"}, load_done, 0);
      chk({tag, "_load_error"}, load_error, 0);
   endtask

   always @(negedge CLK) begin
      logic [15:0] e;
      if (wr_en === 1'b1) begin
         writes++;
         chk("wr_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e[15:8]));
            chk("wr_data", 32'(wr_data), 32'(e[7:0]));
         end
      end
      if (wr_en4 === 1'b1) writes4++;
   end

   initial begin
      // 1: reset state, then a good 3-byte image back-to-back
      idle(3);
      chk_reset_vals("rst");
      reset = 1'b0;
      chk("rst_ready_lag", in_ready, 0);
      idle(1);
      chk("ready_after_rst", in_ready, 1);
      push(0, 8'h11); push(1, 8'h22); push(2, 8'h33);
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
      chk("t1_done", load_done, 1);
      chk("t1_hold", cpu_hold, 0);
      chk("t1_err", load_error, 0);
      chk("t1_ready", in_ready, 0);
      chk("t1_writes", writes, 3);
      chk("t1_addr_hold", wr_addr, 8'h02);
      chk("t1_data_hold", wr_data, 8'h33);

      // 2: checksum mismatch
      pulse_restart();
      chk("rs_done", load_done, 0);
      chk("rs_hold", cpu_hold, 1);
      chk("rs_ready", in_ready, 1);
      push(0, 8'h10); push(1, 8'h20);
      send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
      chk("t2_err", load_error, 1);
      chk("t2_hold", cpu_hold, 1);
      chk("t2_done", load_done, 0);
      chk("t2_writes", writes, 5);

      // 3: noise then a 1-byte image, with idle gaps
      pulse_restart();
      send(8'h00); idle(3); send(8'hFF); idle(3); send(8'h5A); idle(3);
      push(0, 8'h7F);
      send(8'hA5); idle(3); send(8'h01); idle(3); send(8'h7F); idle(3); send(8'h7F);
      chk("t3_done", load_done, 1);
      chk("t3_writes", writes, 6);

      // 4: full 256-entry image (LEN=0), then over-length on ADDR_W=4
      pulse_restart();
      send(8'hA5); send(8'h00);
      for (int i = 0; i < 256; i++) begin
         push(i, 8'(i));
         send(8'(i));
      end
      send(8'h80);
      chk("t4_done", load_done, 1);
      chk("t4_err", load_error, 0);
      chk("t4_writes", writes, 262);
      send(8'hA5, 1'b1); send(8'h11, 1'b1);
      chk("t4_a4_err", load_error4, 1);
      chk("t4_a4_hold", cpu_hold4, 1);
      chk("t4_a4_ready", in_ready4, 0);
      chk("t4_a4_writes", writes4, 0);

      // 5: idle timeout fires exactly 10 cycles after the last accept
      pulse_restart();
      push(0, 8'h01);
      send(8'hA5); send(8'h02); send(8'h01);
      idle(9);
      chk("t5_err_before", load_error, 0);
      idle(1);
      chk("t5_err_at10", load_error, 1);
      chk("t5_hold", cpu_hold, 1);
      pulse_restart();
      push(0, 8'h01); push(1, 8'h02);
      send(8'hA5); send(8'h02); send(8'h01);
      @(posedge CLK); idle(8);
      send(8'h02);
      chk("t5_accept_wins", load_error, 0);
      send(8'h03);
      chk("t5_done", load_done, 1);

      // 6: restart with a byte offered mid-DATA, then reset mid-DATA
      pulse_restart();
      push(0, 8'hAA);
      send(8'hA5); send(8'h03); send(8'hAA);
      in_valid = 1'b1; in_data = 8'hBB; restart = 1'b1;
      @(posedge CLK); #1;
      restart = 1'b0; in_valid = 1'b0;
      chk("t6_ready", in_ready, 1);
      chk("t6_done", load_done, 0);
      chk("t6_err", load_error, 0);
      chk("t6_hold", cpu_hold, 1);
      chk("t6_wr_en", wr_en, 0);
      push(0, 8'h44);
      send(8'hA5); send(8'h01); send(8'h44); send(8'h44);
      chk("t6_rearm_done", load_done, 1);
      pulse_restart();
      push(0, 8'h55);
      send(8'hA5); send(8'h03); send(8'h55);
      in_valid = 1'b1; in_data = 8'h66; reset = 1'b1;
      @(posedge CLK); #1;
      chk_reset_vals("t6_rst");
      in_valid = 1'b0;
      reset = 1'b0;
      idle(3);
      chk("end_queue_empty", 32'(exp_q.size()), 0);
      chk("end_writes", writes, pushes);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
